tick_cascade: RTL and testbench

Parametrised multi-stage tick generator: a base divider turns the system clock into a periodic one-cycle tick, and up to NUM_STAGES−1 further stages each divide the previous stage's tick. All stage divisors are runtime-programmable through shadow registers applied glitch-free, with gating, synchronous phase clear and a one-shot mode. It supplies timebases (bus bit-clock enables, polling intervals, timeouts) to the I2C and peripheral controllers.

---
 rtl/tick_cascade.sv | 136 +++++++++++++
 tb/tb_tick_cascade.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_cascade.sv
// ---------------------------------------------------------------------------
// tick_cascade
//
// Multi-stage tick generator. Stage 0 divides the system clock (gated by
// en) into a periodic one-cycle tick; every further stage divides the tick
// of the stage before it. Each stage has a live divisor and a shadow
// divisor. The shadow is written at any time through div_load. The live
// divisor picks up the shadow value only at that stage's terminal count or
// on sync_clr, so a period is never cut short or stretched.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   stage-0 count enable
//   sync_clr  in   synchronous phase clear of every stage (highest priority)
//   oneshot   in   1 = halt stage 0 after the first tick of the last stage
//   div_load  in   write div_val into the shadow divisor selected by div_sel
//   div_sel   in   target stage of div_load (out-of-range values ignored)
//   div_val   in   new divisor; 0 is treated as 1
//   ticks     out  one-cycle pulses, bit k belongs to stage k
//   done      out  one-shot completed (sticky until sync_clr / reset)
// ---------------------------------------------------------------------------
module tick_cascade #(
    parameter int CLK_IN_HZ  = 100_000_000,
    parameter int TICK_HZ    = 1_000_000,
    parameter int NUM_STAGES = 3,
    parameter int STAGE_DIV  = 1000,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sync_clr,
    input  logic                  oneshot,
    input  logic                  div_load,
    input  logic [SEL_W-1:0]      div_sel,
    input  logic [CNT_W-1:0]      div_val,
    output logic [NUM_STAGES-1:0] ticks,
    output logic                  done
);

    // Reset divisors, clamped to 1 so a degenerate parameter set still
    // produces a valid (every-event) tick rather than a zero divisor.
    localparam logic [CNT_W-1:0] D0_INIT =
        CNT_W'((CLK_IN_HZ / TICK_HZ < 1) ? 1 : CLK_IN_HZ / TICK_HZ);
    localparam logic [CNT_W-1:0] DK_INIT =
        CNT_W'((STAGE_DIV < 1) ? 1 : STAGE_DIV);

    logic [CNT_W-1:0]      cnt     [NUM_STAGES];
    logic [CNT_W-1:0]      div_act [NUM_STAGES];
    logic [CNT_W-1:0]      div_shd [NUM_STAGES];
    logic [NUM_STAGES-1:0] stage_evt;
    logic [NUM_STAGES-1:0] load_hit;
    logic [CNT_W-1:0]      load_val;
    logic                  halted;

    // A divisor of 0 would never reach terminal count, so it is stored as 1.
    assign load_val = (div_val == '0) ? CNT_W'(1) : div_val;

    // Decode which shadow register a div_load targets. A div_sel beyond the
    // last stage matches no bit, which is how out-of-range writes are dropped.
    always_comb begin
        load_hit = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            load_hit[k] = div_load && (div_sel == SEL_W'(k));
        end
    end

    // Count events per stage: stage 0 counts enabled clocks until the
    // one-shot has halted it, later stages count the registered tick of the
    // stage before them, which gives the one-cycle latency per stage.
    always_comb begin
        stage_evt    = '0;
        stage_evt[0] = en && !halted;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_evt[k] = ticks[k-1];
        end
    end

    // Main state update. sync_clr wins over everything; a div_load in the
    // same cycle lands in the shadow and is also taken straight into the
    // live divisor so the cleared cascade starts with the new period. In
    // normal operation the live divisor is refreshed only on wrap, using the
    // shadow value as it stood before this cycle's load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                cnt[k]     <= '0;
                div_act[k] <= (k == 0) ? D0_INIT : DK_INIT;
                div_shd[k] <= (k == 0) ? D0_INIT : DK_INIT;
            end
            ticks  <= '0;
            done   <= 1'b0;
            halted <= 1'b0;
        end else if (sync_clr) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                cnt[k] <= '0;
                if (load_hit[k]) begin
                    div_shd[k] <= load_val;
                    div_act[k] <= load_val;
                end else begin
                    div_act[k] <= div_shd[k];
                end
            end
            ticks  <= '0;
            done   <= 1'b0;
            halted <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (load_hit[k]) begin
                    div_shd[k] <= load_val;
                end
                if (stage_evt[k]) begin
                    if (cnt[k] == div_act[k] - CNT_W'(1)) begin
                        cnt[k]     <= '0;
                        ticks[k]   <= 1'b1;
                        div_act[k] <= div_shd[k];
                    end else begin
                        cnt[k]     <= cnt[k] + CNT_W'(1);
                        ticks[k]   <= 1'b0;
                    end
                end else begin
                    ticks[k] <= 1'b0;
                end
            end
            // The last-stage tick seen high arms done and freezes stage 0 on
            // the same edge; both stay set until sync_clr or reset.
            if (oneshot && ticks[NUM_STAGES-1]) begin
                done   <= 1'b1;
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tick_cascade.sv
// ---------------------------------------------------------------------------
// tb_tick_cascade
//
// Self-checking bench for tick_cascade (100/10 base divider, 3 stages,
// stage divisor 4). A behavioural model keeps, per stage, the number of
// input events still to go before the next tick, and predicts ticks/done
// every cycle. Directed steps walk through the main scenarios, then a
// randomised phase mixes enables, loads, clears and one-shot requests.
// ---------------------------------------------------------------------------
module tb_tick_cascade;

    localparam int NS = 3;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          sync_clr;
    logic          oneshot;
    logic          div_load;
    logic [1:0]    div_sel;
    logic [31:0]   div_val;
    logic [NS-1:0] ticks;
    logic          done;

    tick_cascade #(
        .CLK_IN_HZ (100),
        .TICK_HZ   (10),
        .NUM_STAGES(NS),
        .STAGE_DIV (4),
        .CNT_W     (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync_clr(sync_clr),
        .oneshot (oneshot),
        .div_load(div_load),
        .div_sel (div_sel),
        .div_val (div_val),
        .ticks   (ticks),
        .done    (done)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmpCount  = 0;
    int failCount = 0;
    int cyc       = 0;
    int base      = 0;

    // Reference model state: events remaining per stage, shadow divisors,
    // predicted outputs and halt flag.
    int       remain [NS];
    int       shadow [NS];
    bit [NS-1:0] mTicks;
    bit       mDone;
    bit       mHalt;

    // Observations relative to the last markBase call.
    int firstT [NS];
    int countT [NS];
    int doneFirst;
    int t0q [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        cmpCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)",
                   tag, observed, expected, cyc);
        end
    endtask

    task automatic modelReset();
        remain[0] = 10; shadow[0] = 10;
        for (int k = 1; k < NS; k++) begin
            remain[k] = 4; shadow[k] = 4;
        end
        mTicks = '0;
        mDone  = 1'b0;
        mHalt  = 1'b0;
    endtask

    // One clock edge worth of behaviour, using the inputs as driven.
    task automatic modelStep();
        bit [NS-1:0] nt;
        bit          ev;
        int          v;
        v = (div_val == 0) ? 1 : int'(div_val);
        if (sync_clr) begin
            if (div_load && div_sel < NS) shadow[div_sel] = v;
            for (int k = 0; k < NS; k++) remain[k] = shadow[k];
            mTicks = '0;
            mDone  = 1'b0;
            mHalt  = 1'b0;
        end else begin
            nt = '0;
            for (int k = 0; k < NS; k++) begin
                ev = (k == 0) ? (en && !mHalt) : mTicks[k-1];
                if (ev) begin
                    remain[k]--;
                    if (remain[k] == 0) begin
                        nt[k]     = 1'b1;
                        remain[k] = shadow[k];
                    end
                end
            end
            if (oneshot && mTicks[NS-1]) begin
                mDone = 1'b1;
                mHalt = 1'b1;
            end
            mTicks = nt;
            if (div_load && div_sel < NS) shadow[div_sel] = v;
        end
    endtask

    task automatic markBase();
        base      = cyc;
        doneFirst = -1;
        t0q.delete();
        for (int k = 0; k < NS; k++) begin
            firstT[k] = -1;
            countT[k] = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge and compare
    // the outputs one time unit later.
    task automatic applyStimulus(input bit e, input bit sc, input bit os,
                                 input bit ld, input logic [1:0] sel,
                                 input logic [31:0] val);
        en = e; sync_clr = sc; oneshot = os;
        div_load = ld; div_sel = sel; div_val = val;
        @(posedge clk);
        modelStep();
        #1;
        cyc++;
        checkOutput("ticks", 32'(ticks), 32'(mTicks));
        checkOutput("done", 32'(done), 32'(mDone));
        for (int k = 0; k < NS; k++) begin
            if (ticks[k]) begin
                countT[k]++;
                if (firstT[k] < 0) firstT[k] = cyc - base;
            end
        end
        if (ticks[0]) t0q.push_back(cyc - base);
        if (done && doneFirst < 0) doneFirst = cyc - base;
    endtask

    task automatic runIdle(input int n, input bit e, input bit os);
        for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, os, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; oneshot = 1'b0;
        div_load = 1'b0; div_sel = '0; div_val = '0;
        modelReset();
        markBase();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ticks", 32'(ticks), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running cascade: 10 / 40 / 160 cycle periods.
        $display("[TB] cascade periods");
        markBase();
        runIdle(170, 1'b1, 1'b0);
        checkOutput("first_t0", firstT[0], 32'd10);
        checkOutput("first_t1", firstT[1], 32'd41);
        checkOutput("first_t2", firstT[2], 32'd162);
        checkOutput("count_t0", countT[0], 32'd17);
        checkOutput("count_t1", countT[1], 32'd4);
        checkOutput("count_t2", countT[2], 32'd1);

        // Mid-period divisor load: current period finishes, then period 5.
        $display("[TB] divisor load");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        markBase();
        runIdle(3, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd5);
        runIdle(18, 1'b1, 1'b0);
        checkOutput("load_t0_a", t0q[0], 32'd10);
        checkOutput("load_t0_b", t0q[1], 32'd15);
        checkOutput("load_t0_c", t0q[2], 32'd20);
        // Out-of-range select ignored, zero divisor means every event.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 32'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0);
        runIdle(8, 1'b1, 1'b0);
        markBase();
        runIdle(10, 1'b1, 1'b0);
        checkOutput("div1_count_t0", countT[0], 32'd10);

        // Enable held low 7 cycles at cnt[0]=6 delays the tick by 7.
        $display("[TB] enable gating");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'd10);
        markBase();
        runIdle(6, 1'b1, 1'b0);
        runIdle(7, 1'b0, 1'b0);
        runIdle(4, 1'b1, 1'b0);
        checkOutput("gated_t0", firstT[0], 32'd17);
        runIdle(5, 1'b0, 1'b0);

        // Clear combined with a stage-1 load takes the new divisor at once.
        $display("[TB] clear with load");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 32'd2);
        checkOutput("clr_ticks", 32'(ticks), 32'd0);
        markBase();
        runIdle(65, 1'b1, 1'b0);
        checkOutput("clr_first_t1", firstT[1], 32'd21);
        checkOutput("clr_count_t1", countT[1], 32'd3);

        // One-shot: a single last-stage tick, done next cycle, then frozen.
        $display("[TB] one-shot");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'd4);
        markBase();
        runIdle(170, 1'b1, 1'b1);
        checkOutput("os_first_t2", firstT[2], 32'd162);
        checkOutput("os_done_at", doneFirst, 32'd163);
        markBase();
        runIdle(250, 1'b1, 1'b1);
        runIdle(250, 1'b1, 1'b0);
        checkOutput("os_quiet_t2", countT[2], 32'd0);
        checkOutput("os_quiet_t0", countT[0], 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        markBase();
        runIdle(12, 1'b1, 1'b0);
        checkOutput("os_resume_t0", firstT[0], 32'd10);

        // Asynchronous reset in the middle of counting.
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        markBase();
        runIdle(24, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd3);
        runIdle(5, 1'b1, 1'b0);
        checkOutput("pre_rst_t0", 32'(ticks[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_ticks", 32'(ticks), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        markBase();
        runIdle(12, 1'b1, 1'b0);
        checkOutput("rst_first_t0", firstT[0], 32'd10);

        // Randomised mix, checked cycle by cycle against the model.
        $display("[TB] random phase");
        begin
            bit os;
            os = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 199) == 0) os = ~os;
                applyStimulus($urandom_range(0, 3) != 0,
                              $urandom_range(0, 99) == 0,
                              os,
                              $urandom_range(0, 7) == 0,
                              2'($urandom_range(0, 3)),
                              32'($urandom_range(0, 5)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
